// File: rtl/mcb_write_gen.sv
// MCB user-port write traffic generator: fills one burst of pattern data,
// issues the write command, and walks the burst address across a window.
// Ports: clk, rst (sync, active-high); start/stop/continuous/mode control;
//   cmd_full/wr_full back-pressure; cmd_* command port; wr_* data port;
//   busy, pass_done (pulse with last command of a pass), pass_cnt.
module mcb_write_gen #(
  parameter int              DATA_W     = 32,
  parameter int              BURST_LEN  = 64,
  parameter int              ADDR_W     = 30,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 30'h0FFFFFFF,
  parameter logic [31:0]     SEED       = 32'hACE1_0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [1:0]          mode,
  input  logic                cmd_full,
  input  logic                wr_full,
  output logic                cmd_en,
  output logic [2:0]          cmd_instr,
  output logic [5:0]          cmd_bl,
  output logic [ADDR_W-1:0]   cmd_byte_addr,
  output logic                wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_mask,
  output logic                busy,
  output logic                pass_done,
  output logic [15:0]         pass_cnt
);

  localparam int     BPW   = DATA_W / 8;
  localparam int     LANES = DATA_W / 32;
  localparam longint BPB   = longint'(BURST_LEN) * BPW;
  localparam longint LAST_L =
    ((longint'(END_ADDR) + 1) / BPB - 1) * BPB;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_L);
  localparam logic [ADDR_W-1:0] BPB_A     = ADDR_W'(BPB);
  localparam logic [31:0] START_WORD =
    32'(longint'(START_ADDR) / BPW);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CMD,
    S_NEXT
  } state_t;

  state_t        state;
  logic [1:0]    mode_q;
  logic          cont_q;
  logic [CW-1:0] wcnt;
  logic          at_last;

  function automatic logic [DATA_W-1:0] init_pat(
    input logic [1:0] m
  );
    logic [DATA_W-1:0] p;
    unique case (m)
      2'd0:    p = {BPW{8'hAA}};
      2'd1:    p = {LANES{START_WORD}};
      2'd2:    p = {LANES{SEED}};
      default: p = DATA_W'(1);
    endcase
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] next_pat(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] cur
  );
    logic [31:0]       lane;
    logic [DATA_W-1:0] p;
    lane = cur[31:0];
    unique case (m)
      2'd0: p = ~cur;
      2'd1: p = {LANES{lane + 32'd1}};
      2'd2: p = {LANES{lane[30:0],
                  lane[31] ^ lane[21] ^ lane[1] ^ lane[0]}};
      default: p = {cur[DATA_W-2:0], cur[DATA_W-1]};
    endcase
    return p;
  endfunction

  assign cmd_instr = 3'b000;
  assign cmd_bl    = 6'(BURST_LEN - 1);
  assign wr_mask   = '0;
  assign at_last   = (cmd_byte_addr == LAST_ADDR);

  // Gated by wr_full in the same cycle so no word is pushed into a full FIFO.
  assign wr_en = (state == S_FILL) & ~wr_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= 2'd0;
      cont_q        <= 1'b0;
      wcnt          <= '0;
      cmd_en        <= 1'b0;
      cmd_byte_addr <= START_ADDR;
      wr_data       <= '0;
      busy          <= 1'b0;
      pass_done     <= 1'b0;
      pass_cnt      <= 16'd0;
    end else begin
      cmd_en    <= 1'b0;
      pass_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !stop) begin
            mode_q        <= mode;
            cont_q        <= continuous;
            cmd_byte_addr <= START_ADDR;
            wr_data       <= init_pat(mode);
            wcnt          <= '0;
            busy          <= 1'b1;
            state         <= S_FILL;
          end
        end
        S_FILL: begin
          if (!wr_full) begin
            wr_data <= next_pat(mode_q, wr_data);
            if (wcnt == LAST_WORD) begin
              wcnt  <= '0;
              state <= S_CMD;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_CMD: begin
          if (!cmd_full) begin
            cmd_en <= 1'b1;
            // pass_done lines up with the command of the last burst
            if (at_last) begin
              pass_done <= 1'b1;
              if (pass_cnt != 16'hFFFF)
                pass_cnt <= pass_cnt + 16'd1;
            end
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (at_last) begin
            cmd_byte_addr <= START_ADDR;
            wr_data       <= init_pat(mode_q);
          end else begin
            cmd_byte_addr <= cmd_byte_addr + BPB_A;
          end
          if (stop || (at_last && !cont_q)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcb_write_gen.sv
// Self-checking bench for mcb_write_gen: random back-pressure and
// pattern data checked against a per-pass behavioural model.
module tb_mcb_write_gen;

  localparam int DW = 32;
  localparam int BL = 64;
  localparam int AW = 30;
  localparam logic [AW-1:0] START = '0;
  localparam logic [AW-1:0] ENDA  = 30'h3FF;
  localparam logic [31:0]   SEED  = 32'hACE1_0001;
  localparam int BPB = BL * DW / 8;
  localparam int NB  = int'((ENDA + 1 - START) / BPB);
  localparam int WPP = NB * BL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          cmd_full = 1'b0;
  logic          wr_full = 1'b0;
  logic          cmd_en;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_byte_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW/8-1:0] wr_mask;
  logic          busy;
  logic          pass_done;
  logic [15:0]   pass_cnt;

  int total = 0;
  int bad = 0;
  int exp_pcnt = 0;

  mcb_write_gen #(
    .DATA_W(DW), .BURST_LEN(BL), .ADDR_W(AW),
    .START_ADDR(START), .END_ADDR(ENDA), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .continuous(continuous), .mode(mode),
    .cmd_full(cmd_full), .wr_full(wr_full),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .wr_en(wr_en),
    .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy),
    .pass_done(pass_done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  // monitor: record traffic on the falling edge
  logic [DW-1:0] wq[$];
  logic [AW-1:0] aq[$];
  int nq[$];
  int pdq[$];
  int viol = 0;
  int early = 0;
  int pd_alone = 0;
  int bad_fix = 0;
  int since = 0;

  always @(negedge clk) begin
    if (rst) begin
      since = 0;
    end else begin
      if (wr_en) begin
        if (wr_full) viol++;
        wq.push_back(wr_data);
        since++;
      end
      if (cmd_en) begin
        if (wr_en) early++;
        if (cmd_instr !== 3'b000 || cmd_bl !== 6'(BL - 1)) bad_fix++;
        aq.push_back(cmd_byte_addr);
        nq.push_back(since);
        since = 0;
        if (pass_done) pdq.push_back(aq.size() - 1);
      end
      if (pass_done && !cmd_en) pd_alone++;
      if (wr_mask !== '0) bad_fix++;
    end
  end

  // model: word k of a pass (k counted from the pass start)
  function automatic logic [DW-1:0] exp_word(input int m, input int k);
    int kk;
    logic [31:0] v;
    logic [DW-1:0] w;
    kk = k % WPP;
    w = '0;
    case (m)
      0: w = (kk % 2 == 0) ? {DW/8{8'hAA}} : {DW/8{8'h55}};
      1: begin
        v = 32'(START / (DW / 8)) + 32'(kk);
        w = {DW/32{v}};
      end
      2: begin
        v = SEED;
        repeat (kk) v = {v[30:0], ^(v & 32'h8020_0003)};
        w = {DW/32{v}};
      end
      default: w[kk % DW] = 1'b1;
    endcase
    return w;
  endfunction

  function automatic int data_errs(input int base, input int m,
                                   input int n);
    int e;
    e = 0;
    if (wq.size() < base + n) return n;
    for (int i = 0; i < n; i++)
      if (wq[base + i] !== exp_word(m, i)) e++;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_words(input int base, input int n,
                            input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (wq.size() - base >= n) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (cmd_en !== 1'b0 || wr_en !== 1'b0 || pass_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b%b%b want=000",
               cmd_en, wr_en, pass_done);
    end
    total++;
    if (wr_data !== '0) begin
      bad++;
      $display("FAIL reset_wr_data got=%h want=0", wr_data);
    end
    total++;
    if (cmd_byte_addr !== START) begin
      bad++;
      $display("FAIL reset_addr got=%h want=%h", cmd_byte_addr, START);
    end
    total++;
    if (busy !== 1'b0 || pass_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_busy_cnt got=%b/%0d want=0/0", busy, pass_cnt);
    end
    total++;
    if (cmd_instr !== 3'b000 || cmd_bl !== 6'(BL - 1) || wr_mask !== '0)
    begin
      bad++;
      $display("FAIL reset_fixed got=%b/%0d/%h want=000/%0d/0",
               cmd_instr, cmd_bl, wr_mask, BL - 1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pass;
    int wb, ab, pb, eb, pab;
    bit to;
    wb = wq.size(); ab = aq.size(); pb = pdq.size();
    eb = early; pab = pd_alone;
    mode = 2'd0;
    continuous = 1'b0;
    pulse_start();
    wait_idle(3000, to);
    exp_pcnt++;
    total++;
    if (to) begin
      bad++;
      $display("FAIL single_timeout got=busy want=idle");
    end
    total++;
    if (wq.size() - wb != WPP) begin
      bad++;
      $display("FAIL single_words got=%0d want=%0d", wq.size() - wb, WPP);
    end
    total++;
    if (data_errs(wb, 0, WPP) != 0) begin
      bad++;
      $display("FAIL single_data got=%0d_bad_words want=0",
               data_errs(wb, 0, WPP));
    end
    total++;
    if (aq.size() - ab != NB) begin
      bad++;
      $display("FAIL single_cmds got=%0d want=%0d", aq.size() - ab, NB);
    end
    for (int i = 0; i < NB && ab + i < aq.size(); i++) begin
      total++;
      if (aq[ab + i] !== AW'(START + i * BPB) || nq[ab + i] != BL) begin
        bad++;
        $display("FAIL single_cmd%0d got=%h/%0d want=%h/%0d", i,
                 aq[ab + i], nq[ab + i], AW'(START + i * BPB), BL);
      end
    end
    total++;
    if (pdq.size() - pb != 1 || pd_alone != pab) begin
      bad++;
      $display("FAIL single_pass_done got=%0d want=1",
               pdq.size() - pb);
    end else begin
      total++;
      if (pdq[pb] != ab + NB - 1) begin
        bad++;
        $display("FAIL single_pd_cmd got=%0d want=%0d",
                 pdq[pb] - ab, NB - 1);
      end
    end
    total++;
    if (pass_cnt !== 16'(exp_pcnt) || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end got=%0d/%b want=%0d/0",
               pass_cnt, busy, exp_pcnt);
    end
    total++;
    if (early != eb) begin
      bad++;
      $display("FAIL single_order got=%0d want=0", early - eb);
    end
  endtask

  task automatic test_start_with_stop;
    int ab;
    ab = aq.size();
    stop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || aq.size() != ab) begin
      bad++;
      $display("FAIL start_stop got=%b%b want=00", busy, wr_en);
    end
    stop = 1'b0;
    tick();
  endtask

  task automatic test_wr_full_random;
    int wb, ab, vb, errs;
    bit done;
    wb = wq.size(); ab = aq.size(); vb = viol;
    mode = 2'd1;
    continuous = 1'b0;
    pulse_start();
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      wr_full = 1'($urandom_range(0, 1));
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    wr_full = 1'b0;
    exp_pcnt++;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wrfull_timeout got=busy want=idle");
    end
    total++;
    if (viol != vb) begin
      bad++;
      $display("FAIL wrfull_push got=%0d want=0", viol - vb);
    end
    total++;
    if (wq.size() - wb != WPP) begin
      bad++;
      $display("FAIL wrfull_words got=%0d want=%0d", wq.size() - wb, WPP);
    end
    total++;
    if (data_errs(wb, 1, WPP) != 0) begin
      bad++;
      $display("FAIL wrfull_data got=%0d_bad_words want=0",
               data_errs(wb, 1, WPP));
    end
    errs = 0;
    for (int i = 0; i < NB && ab + i < aq.size(); i++)
      if (nq[ab + i] != BL || aq[ab + i] !== AW'(START + i * BPB)) errs++;
    total++;
    if (aq.size() - ab != NB || errs != 0) begin
      bad++;
      $display("FAIL wrfull_cmds got=%0d_cmds/%0d_bad want=%0d/0",
               aq.size() - ab, errs, NB);
    end
    total++;
    if (pass_cnt !== 16'(exp_pcnt)) begin
      bad++;
      $display("FAIL wrfull_pcnt got=%0d want=%0d", pass_cnt, exp_pcnt);
    end
  endtask

  task automatic test_cmd_full;
    int wb, ab, held;
    bit to;
    wb = wq.size(); ab = aq.size();
    mode = 2'd3;
    continuous = 1'b0;
    cmd_full = 1'b1;
    pulse_start();
    wait_words(wb, BL, 500, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL cmdfull_fill got=%0d want=%0d", wq.size() - wb, BL);
    end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_en !== 1'b0 || cmd_byte_addr !== START) held++;
    end
    total++;
    if (held != 0 || aq.size() != ab) begin
      bad++;
      $display("FAIL cmdfull_hold got=%0d_bad_cycles want=0", held);
    end
    cmd_full = 1'b0;
    tick();
    total++;
    if (cmd_en !== 1'b1 || cmd_byte_addr !== START) begin
      bad++;
      $display("FAIL cmdfull_release got=%b/%h want=1/%h",
               cmd_en, cmd_byte_addr, START);
    end
    wait_idle(2000, to);
    exp_pcnt++;
    total++;
    if (to || wq.size() - wb != WPP || aq.size() - ab != NB) begin
      bad++;
      $display("FAIL cmdfull_run got=%0d_words/%0d_cmds want=%0d/%0d",
               wq.size() - wb, aq.size() - ab, WPP, NB);
    end
    total++;
    if (data_errs(wb, 3, WPP) != 0) begin
      bad++;
      $display("FAIL cmdfull_data got=%0d_bad_words want=0",
               data_errs(wb, 3, WPP));
    end
  endtask

  task automatic test_continuous_stop;
    int wb, ab, pb, stop_at, exp_words, errs;
    bit to;
    wb = wq.size(); ab = aq.size(); pb = pdq.size();
    stop_at = 2 * WPP + BL + BL / 2;
    exp_words = (stop_at / BL + 1) * BL;
    mode = 2'd2;
    continuous = 1'b1;
    pulse_start();
    wait_words(wb, stop_at, 3000, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL cont_progress got=%0d want=%0d",
               wq.size() - wb, stop_at);
    end
    stop = 1'b1;
    wait_idle(1000, to);
    stop = 1'b0;
    continuous = 1'b0;
    exp_pcnt += 2;
    total++;
    if (to || wq.size() - wb != exp_words) begin
      bad++;
      $display("FAIL cont_words got=%0d want=%0d",
               wq.size() - wb, exp_words);
    end
    total++;
    if (data_errs(wb, 2, exp_words) != 0) begin
      bad++;
      $display("FAIL cont_data got=%0d_bad_words want=0",
               data_errs(wb, 2, exp_words));
    end
    errs = 0;
    for (int i = 0; ab + i < aq.size(); i++)
      if (aq[ab + i] !== AW'(START + (i % NB) * BPB) || nq[ab + i] != BL)
        errs++;
    total++;
    if (aq.size() - ab != exp_words / BL || errs != 0) begin
      bad++;
      $display("FAIL cont_cmds got=%0d_cmds/%0d_bad want=%0d/0",
               aq.size() - ab, errs, exp_words / BL);
    end
    total++;
    if (pdq.size() - pb != 2 || pass_cnt !== 16'(exp_pcnt)) begin
      bad++;
      $display("FAIL cont_passes got=%0d/%0d want=2/%0d",
               pdq.size() - pb, pass_cnt, exp_pcnt);
    end
  endtask

  task automatic test_reset_mid_fill;
    int wb, ab;
    bit to;
    wb = wq.size();
    mode = 2'd0;
    continuous = 1'b0;
    pulse_start();
    wait_words(wb, 10, 200, to);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pcnt = 0;
    total++;
    if (to || busy !== 1'b0 || wr_en !== 1'b0 || cmd_en !== 1'b0 ||
        pass_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b%b%b%b want=0000",
               busy, wr_en, cmd_en, pass_done);
    end
    total++;
    if (wr_data !== '0 || cmd_byte_addr !== START ||
        pass_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midrst_regs got=%h/%h/%0d want=0/%h/0",
               wr_data, cmd_byte_addr, pass_cnt, START);
    end
    tick();
    wb = wq.size(); ab = aq.size();
    pulse_start();
    wait_idle(3000, to);
    exp_pcnt++;
    total++;
    if (to || wq.size() - wb != WPP || data_errs(wb, 0, WPP) != 0) begin
      bad++;
      $display("FAIL midrst_rerun got=%0d_words want=%0d_clean",
               wq.size() - wb, WPP);
    end
    total++;
    if (aq.size() - ab != NB || aq.size() == ab ||
        aq[ab] !== START || pass_cnt !== 16'(exp_pcnt)) begin
      bad++;
      $display("FAIL midrst_cmds got=%0d/%0d want=%0d/%0d",
               aq.size() - ab, pass_cnt, NB, exp_pcnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_start_with_stop();
    test_wr_full_random();
    test_cmd_full();
    test_continuous_stop();
    test_reset_mid_fill();
    total++;
    if (bad_fix != 0) begin
      bad++;
      $display("FAIL fixed_fields got=%0d_bad want=0", bad_fix);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
